mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the shared ALU operation select, datapath mux selects and write enables, and consumes the ALU ZERO flag to resolve branches. One instruction is active at a time; the next FETCH starts only after the current instruction completes.

---
 rtl/mips_ctrl_pkg.sv | 75 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 37 +++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 27 ++
 rtl/mips_multicycle_ctrl.sv | 133 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and control-word type for the multicycle MIPS controller.
package mips_ctrl_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation select codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU_SRC_B encodings
  localparam logic [1:0] SRCB_REGB  = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  // PC_SRC encodings
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // 4-bit state encoding; codes 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // One cycle's worth of datapath control
  typedef struct packed {
    logic [2:0] alu_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ior_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  // True for opcodes the controller knows how to sequence
  function automatic logic op_supported(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bus: instruction fields and ZERO in, control strobes out.
interface mips_multicycle_ctrl_if #(
  parameter int OPW  = 6,
  parameter int FNW  = 6,
  parameter int SELW = 3
);
  logic [OPW-1:0]  OPCODE;
  logic [FNW-1:0]  FUNCT;
  logic            ZERO;
  logic [SELW-1:0] ALU_SELECT;
  logic            ALU_SRC_A;
  logic [1:0]      ALU_SRC_B;
  logic [1:0]      PC_SRC;
  logic            PC_WRITE;
  logic            IOR_D;
  logic            MEM_WRITE;
  logic            IR_WRITE;
  logic            REG_DST;
  logic            MEM_TO_REG;
  logic            REG_WRITE;
  logic            ILLEGAL;
  logic [3:0]      STATE;

  // Controller side
  modport master (
    input  OPCODE, FUNCT, ZERO,
    output ALU_SELECT, ALU_SRC_A, ALU_SRC_B, PC_SRC, PC_WRITE, IOR_D,
           MEM_WRITE, IR_WRITE, REG_DST, MEM_TO_REG, REG_WRITE, ILLEGAL, STATE
  );

  // Datapath side
  modport slave (
    output OPCODE, FUNCT, ZERO,
    input  ALU_SELECT, ALU_SRC_A, ALU_SRC_B, PC_SRC, PC_WRITE, IOR_D,
           MEM_WRITE, IR_WRITE, REG_DST, MEM_TO_REG, REG_WRITE, ILLEGAL, STATE
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: ALU operation select plus a flag for supported functs.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FNW  = 6,
  parameter int SELW = 3
) (
  input  logic [FNW-1:0]  funct_i,
  output logic [SELW-1:0] alu_sel_o,
  output logic            funct_valid_o
);

  // Unsupported functs fall back to ADD and are flagged invalid
  always_comb begin
    alu_sel_o     = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  alu_sel_o = ALU_ADD;
      FN_SUB:  alu_sel_o = ALU_SUB;
      FN_AND:  alu_sel_o = ALU_AND;
      FN_OR:   alu_sel_o = ALU_OR;
      FN_SLT:  alu_sel_o = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: Moore-decoded controls, BRANCH PC_WRITE follows ZERO.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int FNW  = 6,
  parameter int SELW = 3
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  mips_multicycle_ctrl_if.master bus
);

  state_t          state_q, state_d;
  ctrl_t           ctrl_dec;
  logic [OPW-1:0]  opcode;
  logic [FNW-1:0]  funct;
  logic [SELW-1:0] fn_alu_sel;
  logic            fn_valid;

  assign opcode = bus.OPCODE;
  assign funct  = bus.FUNCT;

  // Single funct decoder shared by EXECUTE (op select) and ALUWB (validity)
  alu_decoder #(.FNW(FNW), .SELW(SELW)) u_alu_dec (
    .funct_i       (funct),
    .alu_sel_o     (fn_alu_sel),
    .funct_valid_o (fn_valid)
  );

  // State register; reset parks the FSM in FETCH immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; every instruction ends by returning to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_FETCH;
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; anything not named for a state stays 0
  always_comb begin
    ctrl_dec = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_dec.ir_write  = 1'b1;
        ctrl_dec.alu_src_b = SRCB_FOUR;
        ctrl_dec.alu_sel   = ALU_ADD;
        ctrl_dec.pc_src    = PCSRC_ALU;
        ctrl_dec.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl_dec.alu_src_b = SRCB_IMMSH;
        ctrl_dec.alu_sel   = ALU_ADD;
        ctrl_dec.illegal   = !op_supported(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_dec.alu_src_a = 1'b1;
        ctrl_dec.alu_src_b = SRCB_IMM;
        ctrl_dec.alu_sel   = ALU_ADD;
      end
      S_MEMRD: ctrl_dec.ior_d = 1'b1;
      S_MEMWB: begin
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_dec.ior_d     = 1'b1;
        ctrl_dec.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_dec.alu_src_a = 1'b1;
        ctrl_dec.alu_src_b = SRCB_REGB;
        ctrl_dec.alu_sel   = fn_alu_sel;
      end
      S_ALUWB: begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = fn_valid;
        ctrl_dec.illegal   = !fn_valid;
      end
      S_BRANCH: begin
        ctrl_dec.alu_src_a = 1'b1;
        ctrl_dec.alu_src_b = SRCB_REGB;
        ctrl_dec.alu_sel   = ALU_SUB;
        ctrl_dec.pc_src    = PCSRC_ALUOUT;
        ctrl_dec.pc_write  = bus.ZERO;
      end
      S_ADDIWB: ctrl_dec.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_dec.pc_src   = PCSRC_JUMP;
        ctrl_dec.pc_write = 1'b1;
      end
      default: ctrl_dec = '0;
    endcase
  end

  // Reset gates every strobe combinationally so nothing writes after RST_N falls
  always_comb begin
    ctrl_t c;
    c = RST_N ? ctrl_dec : '0;
    bus.ALU_SELECT = c.alu_sel;
    bus.ALU_SRC_A  = c.alu_src_a;
    bus.ALU_SRC_B  = c.alu_src_b;
    bus.PC_SRC     = c.pc_src;
    bus.PC_WRITE   = c.pc_write;
    bus.IOR_D      = c.ior_d;
    bus.MEM_WRITE  = c.mem_write;
    bus.IR_WRITE   = c.ir_write;
    bus.REG_DST    = c.reg_dst;
    bus.MEM_TO_REG = c.mem_to_reg;
    bus.REG_WRITE  = c.reg_write;
    bus.ILLEGAL    = c.illegal;
    bus.STATE      = state_q;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected cycle sequences vs. the controller.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef logic [19:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t exp_q[$];

  mips_multicycle_ctrl_if #(.OPW(6), .FNW(6), .SELW(3)) ifc ();

  mips_multicycle_ctrl #(.OPW(6), .FNW(6), .SELW(3)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packed observation: {STATE, ALU_SELECT, SRC_A, SRC_B, PC_SRC, PC_WRITE, IOR_D,
  //                      MEM_WRITE, IR_WRITE, REG_DST, MEM_TO_REG, REG_WRITE, ILLEGAL}
  function automatic vec_t observe();
    return {ifc.STATE, ifc.ALU_SELECT, ifc.ALU_SRC_A, ifc.ALU_SRC_B, ifc.PC_SRC,
            ifc.PC_WRITE, ifc.IOR_D, ifc.MEM_WRITE, ifc.IR_WRITE, ifc.REG_DST,
            ifc.MEM_TO_REG, ifc.REG_WRITE, ifc.ILLEGAL};
  endfunction

  function automatic vec_t rec(logic [3:0] st, logic [2:0] sel, logic a, logic [1:0] b,
                               logic [1:0] pcs, logic pw, logic ior, logic mw, logic irw,
                               logic rd, logic mtr, logic rw, logic ill);
    return {st, sel, a, b, pcs, pw, ior, mw, irw, rd, mtr, rw, ill};
  endfunction

  // Funct rule: {valid, alu_sel}
  function automatic logic [3:0] funct_rule(logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return {1'b0, 3'b010};
    endcase
  endfunction

  // Expected per-cycle behaviour of one instruction, FETCH through last cycle
  function automatic void build(logic [5:0] op, logic [5:0] fn, logic z);
    logic [3:0] fr;
    logic       known;
    fr = funct_rule(fn);
    known = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
            (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    exp_q.delete();
    exp_q.push_back(rec(S_FETCH, 3'b010, 0, 2'd1, 2'd0, 1, 0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(rec(S_DECODE, 3'b010, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, !known));
    case (op)
      6'b100011: begin
        exp_q.push_back(rec(S_MEMADR, 3'b010, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(S_MEMRD, 3'b000, 0, 2'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(S_MEMWB, 3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0));
      end
      6'b101011: begin
        exp_q.push_back(rec(S_MEMADR, 3'b010, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(S_MEMWR, 3'b000, 0, 2'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0));
      end
      6'b000000: begin
        exp_q.push_back(rec(S_EXECUTE, fr[2:0], 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(S_ALUWB, 3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, fr[3], !fr[3]));
      end
      6'b000100:
        exp_q.push_back(rec(S_BRANCH, 3'b110, 1, 2'd0, 2'd1, z, 0, 0, 0, 0, 0, 0, 0));
      6'b001000: begin
        exp_q.push_back(rec(S_ADDIEX, 3'b010, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(S_ADDIWB, 3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      6'b000010:
        exp_q.push_back(rec(S_JUMP, 3'b000, 0, 2'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0));
      default: ;
    endcase
  endfunction

  // Runs one instruction from FETCH; abort_at >= 0 pulls reset after that cycle's check
  task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, logic z, int abort_at);
    vec_t rst_vec;
    rst_vec = rec(S_FETCH, 3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifc.OPCODE = op;
    ifc.FUNCT  = fn;
    ifc.ZERO   = z;
    build(op, fn, z);
    $display("instr %s op=%b fn=%b z=%0d cycles=%0d", name, op, fn, z, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      #1;
      check($sformatf("%s_c%0d", name, k), 32'(observe()), 32'(exp_q[k]));
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s_rst_async", name), 32'(observe()), 32'(rst_vec));
        @(negedge clk);
        #1;
        check($sformatf("%s_rst_hold", name), 32'(observe()), 32'(rst_vec));
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t        rst_vec;
    logic [5:0]  op, fn;
    logic [5:0]  ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0]  fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    int          pick;
    rst_vec = rec(S_FETCH, 3'b000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    ifc.OPCODE = '0;
    ifc.FUNCT  = '0;
    ifc.ZERO   = 1'b0;

    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset", 32'(observe()), 32'(rst_vec));
    end
    rst_n = 1'b1;

    run_instr("lw",       6'b100011, 6'b000000, 1'b0, -1);
    run_instr("slt",      6'b000000, 6'b101010, 1'b0, -1);
    run_instr("rbad",     6'b000000, 6'b111111, 1'b0, -1);
    run_instr("beq_t",    6'b000100, 6'b000000, 1'b1, -1);
    run_instr("beq_nt",   6'b000100, 6'b000000, 1'b0, -1);
    run_instr("opbad",    6'b111111, 6'b000000, 1'b0, -1);
    run_instr("addi",     6'b001000, 6'b000000, 1'b0, -1);
    run_instr("j",        6'b000010, 6'b000000, 1'b0, -1);
    run_instr("sw_rst",   6'b101011, 6'b000000, 1'b0, 2);
    run_instr("sw",       6'b101011, 6'b000000, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 7);
      op = (pick < 6) ? ops[pick] : 6'($urandom_range(0, 63));
      pick = $urandom_range(0, 6);
      fn = (pick < 5) ? fns[pick] : 6'($urandom_range(0, 63));
      run_instr($sformatf("rnd%0d", i), op, fn, 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
